// File: rtl/ip_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntw_sched_pkg
// Description : Shared types and source indices for the IP TX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ntw_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } sched_state_e;

    localparam int TCP_IDX  = 0;
    localparam int UDP_IDX  = 1;
    localparam int ICMP_IDX = 2;

endpackage
`default_nettype wire

// File: rtl/ip_tx_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder. Returns the first set
//               request bit at or after ptr_i, wrapping N-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        int k;
        k       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            k = int'(ptr_i) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (req_i[k]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ip_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_scheduler
// Description : Packet-level weighted round-robin owner selection for the
//               shared IP TX path, with a stall watchdog that force-releases
//               a grant whose packet stops moving.
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_scheduler #(
    parameter  int S_COUNT  = 3,
    parameter  int WEIGHT_W = 4,
    parameter  int TIMEOUT  = 65536,
    parameter  int CNT_W    = 16,
    localparam int IDX_W    = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enable,
    input  logic [S_COUNT-1:0]          i_req,
    input  logic [S_COUNT*WEIGHT_W-1:0] i_weight,
    input  logic                        i_hdr_fire,
    input  logic                        i_beat_fire,
    input  logic                        i_last_fire,
    output logic                        o_grant_valid,
    output logic [IDX_W-1:0]            o_grant_idx,
    output logic [S_COUNT-1:0]          o_grant_oh,
    output logic                        o_timeout,
    output logic [S_COUNT*CNT_W-1:0]    o_pkt_cnt,
    output logic [CNT_W-1:0]            o_to_cnt
);

    import ntw_sched_pkg::*;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_e                       state_q, state_d;
    logic                               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]                   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [S_COUNT-1:0][WEIGHT_W-1:0]   credit_q, credit_d;
    logic [S_COUNT-1:0][CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]                   to_cnt_q, to_cnt_d;
    logic                               timeout_q, timeout_d;
    logic [WD_W-1:0]                    wd_q, wd_d;

    logic [S_COUNT-1:0][WEIGHT_W-1:0]   w_weight_eff;
    logic [S_COUNT-1:0]                 w_cand;
    logic                               w_pick_found;
    logic [IDX_W-1:0]                   w_pick_idx;
    logic                               w_pkt_done;
    logic                               w_wd_expire;
    logic                               w_wd_last;

    // Per-source helpers: zero weight means one packet, eligibility, one-hot grant
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_src
        assign w_weight_eff[gi] = (i_weight[gi*WEIGHT_W +: WEIGHT_W] == '0)
                                ? WEIGHT_W'(1)
                                : i_weight[gi*WEIGHT_W +: WEIGHT_W];
        assign w_cand[gi]       = i_req[gi] & (credit_q[gi] != '0);
        assign o_grant_oh[gi]   = grant_valid_q & (grant_idx_q == IDX_W'(gi));
    end

    rr_pick #(
        .N (S_COUNT)
    ) u_rr_pick (
        .req_i   (w_cand),
        .ptr_i   (rr_ptr_q),
        .found_o (w_pick_found),
        .idx_o   (w_pick_idx)
    );

    assign w_wd_last = (wd_q == WD_W'(TIMEOUT - 1));

    // Next-state logic: grant selection, packet tracking, watchdog and release bookkeeping
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        credit_d      = credit_q;
        pkt_cnt_d     = pkt_cnt_q;
        to_cnt_d      = to_cnt_q;
        timeout_d     = 1'b0;
        wd_d          = wd_q;
        w_pkt_done    = 1'b0;
        w_wd_expire   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Fires seen here belong to no packet and are dropped
                if (i_enable) begin
                    if (w_pick_found) begin
                        grant_valid_d = 1'b1;
                        grant_idx_d   = w_pick_idx;
                        wd_d          = '0;
                        state_d       = HDR;
                    end else if (|i_req) begin
                        // Round exhausted for every requester: start a new round
                        credit_d = w_weight_eff;
                    end
                end
            end
            HDR: begin
                if (i_hdr_fire && i_last_fire) begin
                    w_pkt_done = 1'b1;
                end else if (i_hdr_fire || i_beat_fire) begin
                    wd_d = '0;
                    if (i_hdr_fire) begin
                        state_d = PAY;
                    end
                end else if (w_wd_last) begin
                    w_wd_expire = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            PAY: begin
                if (i_last_fire) begin
                    w_pkt_done = 1'b1;
                end else if (i_hdr_fire || i_beat_fire) begin
                    wd_d = '0;
                end else if (w_wd_last) begin
                    w_wd_expire = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common release path for normal completion and watchdog release
        if (w_pkt_done || w_wd_expire) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            wd_d          = '0;
            if (grant_idx_q == IDX_W'(S_COUNT - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_q + 1'b1;
            end
            for (int i = 0; i < S_COUNT; i++) begin
                if (grant_idx_q == IDX_W'(i)) begin
                    if (credit_q[i] != '0) begin
                        credit_d[i] = credit_q[i] - 1'b1;
                    end
                    if (w_pkt_done) begin
                        pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
                        // Source keeps priority while it still has credit this round
                        if (credit_q[i] > WEIGHT_W'(1)) begin
                            rr_ptr_d = grant_idx_q;
                        end
                    end
                end
            end
            if (w_wd_expire) begin
                timeout_d = 1'b1;
                if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        end
    end

    // State and counter registers; reset samples the weights as the first round
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= IDX_W'(TCP_IDX);
            credit_q      <= w_weight_eff;
            pkt_cnt_q     <= '0;
            to_cnt_q      <= '0;
            timeout_q     <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            credit_q      <= credit_d;
            pkt_cnt_q     <= pkt_cnt_d;
            to_cnt_q      <= to_cnt_d;
            timeout_q     <= timeout_d;
            wd_q          <= wd_d;
        end
    end

    assign o_grant_valid = grant_valid_q;
    assign o_grant_idx   = grant_idx_q;
    assign o_timeout     = timeout_q;
    assign o_pkt_cnt     = pkt_cnt_q;
    assign o_to_cnt      = to_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_tx_scheduler
// Description : Directed self-checking bench for ip_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_tx_scheduler;

    localparam int S_COUNT  = 3;
    localparam int WEIGHT_W = 4;
    localparam int CNT_W    = 16;
    localparam int TIMEOUT  = 16;

    logic                        i_clk = 1'b0;
    logic                        i_rst;
    logic                        i_enable;
    logic [S_COUNT-1:0]          i_req;
    logic [S_COUNT*WEIGHT_W-1:0] i_weight;
    logic                        i_hdr_fire;
    logic                        i_beat_fire;
    logic                        i_last_fire;
    logic                        o_grant_valid;
    logic [1:0]                  o_grant_idx;
    logic [S_COUNT-1:0]          o_grant_oh;
    logic                        o_timeout;
    logic [S_COUNT*CNT_W-1:0]    o_pkt_cnt;
    logic [CNT_W-1:0]            o_to_cnt;

    int total = 0;
    int bad   = 0;

    // Expected grant order and cycles-to-grant (2 where a credit reload precedes the grant)
    int t1_idx[6] = '{0, 1, 2, 0, 1, 2};
    int t1_lat[6] = '{1, 1, 1, 2, 1, 1};
    int t2_idx[8] = '{0, 0, 0, 1, 2, 0, 0, 0};
    int t2_lat[8] = '{2, 1, 1, 1, 1, 2, 1, 1};
    int t3_lat[3] = '{1, 2, 2};

    ip_tx_scheduler #(
        .S_COUNT  (S_COUNT),
        .WEIGHT_W (WEIGHT_W),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_req         (i_req),
        .i_weight      (i_weight),
        .i_hdr_fire    (i_hdr_fire),
        .i_beat_fire   (i_beat_fire),
        .i_last_fire   (i_last_fire),
        .o_grant_valid (o_grant_valid),
        .o_grant_idx   (o_grant_idx),
        .o_grant_oh    (o_grant_oh),
        .o_timeout     (o_timeout),
        .o_pkt_cnt     (o_pkt_cnt),
        .o_to_cnt      (o_to_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int i);
        return {16'd0, o_pkt_cnt[i*CNT_W +: CNT_W]};
    endfunction

    // Waits (bounded) for the next grant and checks its latency and owner
    task automatic wait_grant(input string tag, input int exp_idx, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            lat++;
            if (o_grant_valid === 1'b1) got = 1'b1;
        end
        chk({tag, "_lat"}, got ? lat : 99, exp_lat);
        chk({tag, "_idx"}, {30'd0, o_grant_idx}, exp_idx);
        chk({tag, "_oh"}, {29'd0, o_grant_oh}, 32'd1 << exp_idx);
    endtask

    // Single-beat packet: header and last beat in the same cycle
    task automatic finish_pkt(input string tag);
        i_hdr_fire  = 1'b1;
        i_beat_fire = 1'b1;
        i_last_fire = 1'b1;
        tick();
        i_hdr_fire  = 1'b0;
        i_beat_fire = 1'b0;
        i_last_fire = 1'b0;
        chk({tag, "_rel"}, {31'd0, o_grant_valid}, 0);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_enable    = 1'b1;
        i_req       = '0;
        i_weight    = {4'd1, 4'd1, 4'd1};
        i_hdr_fire  = 1'b0;
        i_beat_fire = 1'b0;
        i_last_fire = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", {31'd0, o_grant_valid}, 0);
        chk("rst_oh", {29'd0, o_grant_oh}, 0);
        chk("rst_timeout", {31'd0, o_timeout}, 0);
        chk("rst_to_cnt", {16'd0, o_to_cnt}, 0);
        chk("rst_pkt_zero", {31'd0, (o_pkt_cnt === '0)}, 1);

        // T1: equal weights, plain rotation
        i_rst = 1'b0;
        i_req = 3'b111;
        for (int p = 0; p < 6; p++) begin
            wait_grant($sformatf("t1_p%0d", p), t1_idx[p], t1_lat[p]);
            finish_pkt($sformatf("t1_p%0d", p));
        end
        chk("t1_cnt0", pc(0), 2);
        chk("t1_cnt1", pc(1), 2);
        chk("t1_cnt2", pc(2), 2);

        // T2: TCP weight 3, new weights picked up at the next reload
        i_weight = {4'd1, 4'd1, 4'd3};
        for (int p = 0; p < 8; p++) begin
            wait_grant($sformatf("t2_p%0d", p), t2_idx[p], t2_lat[p]);
            finish_pkt($sformatf("t2_p%0d", p));
        end
        chk("t2_cnt0", pc(0), 8);
        chk("t2_cnt1", pc(1), 3);
        chk("t2_cnt2", pc(2), 3);

        // T3: UDP alone with weight 0 (acts as 1): every later packet needs a reload
        i_weight = {4'd1, 4'd0, 4'd3};
        i_req    = 3'b010;
        for (int p = 0; p < 3; p++) begin
            wait_grant($sformatf("t3_p%0d", p), 1, t3_lat[p]);
            finish_pkt($sformatf("t3_p%0d", p));
        end
        chk("t3_cnt1", pc(1), 6);

        // T5: credits TCP=3 UDP=0 ICMP=1, pointer at ICMP; disable mid-packet
        i_weight = {4'd1, 4'd1, 4'd1};
        i_req    = 3'b111;
        wait_grant("t5_g", 2, 1);
        i_hdr_fire = 1'b1;
        tick();
        i_hdr_fire = 1'b0;
        chk("t5_hold_pay", {31'd0, o_grant_valid}, 1);
        i_enable    = 1'b0;
        i_beat_fire = 1'b1;
        tick();
        i_req       = 3'b001;
        i_last_fire = 1'b1;
        tick();
        i_beat_fire = 1'b0;
        i_last_fire = 1'b0;
        i_req       = 3'b111;
        chk("t5_done", {31'd0, o_grant_valid}, 0);
        chk("t5_cnt2", pc(2), 4);
        // Stray fires while idle must not count
        i_hdr_fire  = 1'b1;
        i_beat_fire = 1'b1;
        i_last_fire = 1'b1;
        tick();
        i_hdr_fire  = 1'b0;
        i_beat_fire = 1'b0;
        i_last_fire = 1'b0;
        tick();
        tick();
        chk("t5_no_grant", {31'd0, o_grant_valid}, 0);
        chk("t5_idle_cnt0", pc(0), 8);
        chk("t5_idle_cnt2", pc(2), 4);
        i_enable = 1'b1;
        wait_grant("t5_reen", 0, 1);

        // T6: reset while TCP is in payload
        i_hdr_fire = 1'b1;
        tick();
        i_hdr_fire = 1'b0;
        chk("t6_pay_valid", {31'd0, o_grant_valid}, 1);
        i_rst = 1'b1;
        tick();
        chk("t6_rst_valid", {31'd0, o_grant_valid}, 0);
        chk("t6_rst_oh", {29'd0, o_grant_oh}, 0);
        chk("t6_rst_pkt_zero", {31'd0, (o_pkt_cnt === '0)}, 1);
        i_rst = 1'b0;
        wait_grant("t6_first", 0, 1);

        // T4: TCP granted, no traffic -> watchdog release 16 cycles after grant
        repeat (TIMEOUT - 1) tick();
        chk("t4_pre_to", {31'd0, o_timeout}, 0);
        chk("t4_pre_valid", {31'd0, o_grant_valid}, 1);
        tick();
        chk("t4_to_pulse", {31'd0, o_timeout}, 1);
        chk("t4_to_valid", {31'd0, o_grant_valid}, 0);
        chk("t4_to_cnt", {16'd0, o_to_cnt}, 1);
        chk("t4_no_pkt", pc(0), 0);
        tick();
        chk("t4_pulse_end", {31'd0, o_timeout}, 0);
        chk("t4_next_valid", {31'd0, o_grant_valid}, 1);
        chk("t4_next_idx", {30'd0, o_grant_idx}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
